// File: rtl/iigs_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : iigs_mem_pkg
//  Description : IIgs shadow region map, shadow register bit indices and the
//                drain FSM state type shared by the shadow write queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package iigs_mem_pkg;

    localparam logic [7:0]  c_BANK_00      = 8'h00;
    localparam logic [7:0]  c_BANK_01      = 8'h01;
    // $E0 and $E1 differ only in bit 0
    localparam logic [6:0]  c_SLOW_BANK_HI = 7'h70;

    localparam logic [15:0] c_TXT1_BASE  = 16'h0400;
    localparam logic [15:0] c_TXT1_LIMIT = 16'h07FF;
    localparam logic [15:0] c_TXT2_BASE  = 16'h0800;
    localparam logic [15:0] c_TXT2_LIMIT = 16'h0BFF;
    localparam logic [15:0] c_HGR1_BASE  = 16'h2000;
    localparam logic [15:0] c_HGR1_LIMIT = 16'h3FFF;
    localparam logic [15:0] c_HGR2_BASE  = 16'h4000;
    localparam logic [15:0] c_HGR2_LIMIT = 16'h5FFF;
    localparam logic [15:0] c_SHR_BASE   = 16'h6000;
    localparam logic [15:0] c_SHR_LIMIT  = 16'h9FFF;

    localparam int unsigned c_SH_TXT1 = 0;
    localparam int unsigned c_SH_HGR1 = 1;
    localparam int unsigned c_SH_HGR2 = 2;
    localparam int unsigned c_SH_SHR  = 3;
    localparam int unsigned c_SH_AUX  = 4;
    localparam int unsigned c_SH_TXT2 = 5;
    localparam int unsigned c_SH_IOLC = 6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_REQ       = 2'd2
    } drain_state_t;

    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shadow_write_queue_if.sv
`default_nettype none
// ============================================================================
//  Interface   : shadow_write_queue_if
//  Description : CPU bus side and slow-RAM write port of the shadow queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface shadow_write_queue_if;
    logic        cpu_strobe;
    logic        cpu_we;
    logic [7:0]  cpu_bank;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        io_n;
    logic        stall;
    logic        slow_req;
    logic        slow_bank;
    logic [15:0] slow_addr;
    logic [7:0]  slow_data;
    logic        slow_ack;

    modport master (
        output cpu_strobe, cpu_we, cpu_bank, cpu_addr, cpu_dout, io_n, slow_ack,
        input  stall, slow_req, slow_bank, slow_addr, slow_data
    );

    modport slave (
        input  cpu_strobe, cpu_we, cpu_bank, cpu_addr, cpu_dout, io_n, slow_ack,
        output stall, slow_req, slow_bank, slow_addr, slow_data
    );
endinterface
`default_nettype wire

// File: rtl/shadow_match.sv
`default_nettype none
// ============================================================================
//  Module      : shadow_match
//  Description : Combinational decode of CPU writes that must be mirrored to
//                $E0/$E1. SHADOW_SHR_EN adds the bank $01 $6000-$9FFF region.
//  Revision    : 1.0 - initial release
// ============================================================================
module shadow_match
    import iigs_mem_pkg::*;
(
    input  logic [7:0]  bank,
    input  logic [15:0] addr,
    input  logic [7:0]  shadow,
    input  logic        io_n,
    output logic        match
);

    logic w_bank00, w_bank01, w_main_ok, w_shr_on;
    logic w_txt1, w_txt2, w_hgr1, w_hgr2, w_shr;
    logic w_unused_bits;

    assign w_bank00  = (bank == c_BANK_00);
    assign w_bank01  = (bank == c_BANK_01);
    // AUX inhibit gates every bank $01 term except the SHR one
    assign w_main_ok = w_bank00 | (w_bank01 & ~shadow[c_SH_AUX]);
    assign w_shr_on  = ~shadow[c_SH_SHR];

    assign w_txt1 = in_range(addr, c_TXT1_BASE, c_TXT1_LIMIT) & ~shadow[c_SH_TXT1] & w_main_ok;
    assign w_txt2 = in_range(addr, c_TXT2_BASE, c_TXT2_LIMIT) & ~shadow[c_SH_TXT2] & w_main_ok;
    assign w_hgr1 = in_range(addr, c_HGR1_BASE, c_HGR1_LIMIT)
                  & ((~shadow[c_SH_HGR1] & w_main_ok) | w_shr_on);
    assign w_hgr2 = in_range(addr, c_HGR2_BASE, c_HGR2_LIMIT)
                  & ((~shadow[c_SH_HGR2] & w_main_ok) | w_shr_on);

`ifdef SHADOW_SHR_EN
    assign w_shr = w_bank01 & in_range(addr, c_SHR_BASE, c_SHR_LIMIT) & w_shr_on;
`else
    assign w_shr = 1'b0;
`endif

    assign match = (w_bank00 | w_bank01) & io_n & (w_txt1 | w_txt2 | w_hgr1 | w_hgr2 | w_shr);

    assign w_unused_bits = &{1'b0, shadow[c_SH_IOLC], shadow[7]};

endmodule
`default_nettype wire

// File: rtl/shadow_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : shadow_write_queue
//  Description : Posted FIFO copying shadowed bank $00/$01 writes into slow
//                RAM $E0/$E1, drained at most once per slow-bus slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module shadow_write_queue
    import iigs_mem_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SLOW_DIV = 14
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [7:0]               shadow,
    shadow_write_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned c_PW = $clog2(DEPTH);
    localparam int unsigned c_LW = c_PW + 1;
    localparam int unsigned c_SW = $clog2(SLOW_DIV);
    localparam int unsigned c_EW = 1 + 16 + 8;
    localparam logic [c_SW-1:0] c_SLOT_LAST = c_SW'(SLOW_DIV - 1);
    localparam logic [c_LW-1:0] c_FULL      = c_LW'(DEPTH);

    logic [c_EW-1:0] r_mem [DEPTH];
    logic [c_EW-1:0] w_head;
    logic [c_PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_LW-1:0] r_level, w_level_nxt;
    logic [c_SW-1:0] r_slot_cnt;
    drain_state_t    r_state, w_state_nxt;
    logic            w_match, w_push, w_pop, w_full_hz, w_order_hz, w_slot_hit, w_load;
    logic            r_slow_bank;
    logic [15:0]     r_slow_addr;
    logic [7:0]      r_slow_data;

    shadow_match u_match (
        .bank   (bus.cpu_bank),
        .addr   (bus.cpu_addr),
        .shadow (shadow),
        .io_n   (bus.io_n),
        .match  (w_match)
    );

    assign w_pop      = (r_state == ST_REQ) & bus.slow_ack;
    assign w_full_hz  = bus.cpu_strobe & bus.cpu_we & w_match & (r_level == c_FULL) & ~w_pop;
    assign w_order_hz = bus.cpu_strobe & (bus.cpu_bank[7:1] == c_SLOW_BANK_HI) & (r_level != '0);
    assign bus.stall  = w_full_hz | w_order_hz;
    assign w_push     = bus.cpu_strobe & bus.cpu_we & w_match & ~bus.stall;
    assign w_slot_hit = (r_slot_cnt == c_SLOT_LAST);
    assign w_head     = r_mem[r_rd_ptr];

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            // going straight to REQ on a slot edge gives the one-cycle best case
            ST_IDLE:      if (r_level != '0) w_state_nxt = w_slot_hit ? ST_REQ : ST_WAIT_SLOT;
            ST_WAIT_SLOT: if (w_slot_hit) w_state_nxt = ST_REQ;
            ST_REQ:       if (bus.slow_ack)
                              w_state_nxt = (w_level_nxt != '0) ? ST_WAIT_SLOT : ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_load = (w_state_nxt == ST_REQ) && (r_state != ST_REQ);

    always_ff @(posedge clk_sys) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.cpu_bank[0], bus.cpu_addr, bus.cpu_dout};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_slot_cnt  <= '0;
            r_slow_bank <= 1'b0;
            r_slow_addr <= '0;
            r_slow_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_level    <= w_level_nxt;
            r_slot_cnt <= w_slot_hit ? '0 : r_slot_cnt + 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            // slow outputs are latched on entry to REQ and held until the ack
            if (w_load) begin
                r_slow_bank <= w_head[24];
                r_slow_addr <= w_head[23:8];
                r_slow_data <= w_head[7:0];
            end
        end
    end

    assign bus.slow_req  = (r_state == ST_REQ);
    assign bus.slow_bank = r_slow_bank;
    assign bus.slow_addr = r_slow_addr;
    assign bus.slow_data = r_slow_data;
    assign level         = r_level;

endmodule
`default_nettype wire

// File: tb/tb_shadow_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shadow_write_queue
//  Description : Directed self-checking bench for shadow_write_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shadow_write_queue;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned SLOW_DIV = 14;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic [7:0] shadow;
    logic [3:0] level;
    int         n_tests = 0;
    int         n_fail  = 0;

    shadow_write_queue_if bus_if ();

    shadow_write_queue #(.DEPTH(DEPTH), .SLOW_DIV(SLOW_DIV)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .shadow  (shadow),
        .bus     (bus_if),
        .level   (level)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] bank, input logic [15:0] addr, input logic [7:0] data);
        bus_if.cpu_strobe = 1'b1;
        bus_if.cpu_we     = 1'b1;
        bus_if.cpu_bank   = bank;
        bus_if.cpu_addr   = addr;
        bus_if.cpu_dout   = data;
        @(posedge clk_sys); #1;
        bus_if.cpu_strobe = 1'b0;
        bus_if.cpu_we     = 1'b0;
    endtask

    task automatic wait_req(input int max_cyc, output bit ok);
        int n = 0;
        while (!bus_if.slow_req && n < max_cyc) begin
            @(posedge clk_sys); #1;
            n++;
        end
        ok = bus_if.slow_req;
    endtask

    task automatic ack_once();
        bus_if.slow_ack = 1'b1;
        @(posedge clk_sys); #1;
        bus_if.slow_ack = 1'b0;
    endtask

    task automatic drain_all();
        bit ok;
        for (int i = 0; i < int'(DEPTH) + 2 && level != 0; i++) begin
            wait_req(2 * SLOW_DIV, ok);
            if (!ok) break;
            ack_once();
        end
        check_val("drain_empty", 32'(level), 0);
    endtask

    initial begin
        bit ok, early, seen;
        int n;

        reset_n           = 1'b0;
        shadow            = 8'h00;
        bus_if.cpu_strobe = 1'b0;
        bus_if.cpu_we     = 1'b0;
        bus_if.cpu_bank   = 8'h00;
        bus_if.cpu_addr   = 16'h0000;
        bus_if.cpu_dout   = 8'h00;
        bus_if.io_n       = 1'b1;
        bus_if.slow_ack   = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        check_val("rst_req",   32'(bus_if.slow_req),  0);
        check_val("rst_level", 32'(level),            0);
        check_val("rst_stall", 32'(bus_if.stall),     0);
        check_val("rst_bank",  32'(bus_if.slow_bank), 0);
        check_val("rst_addr",  32'(bus_if.slow_addr), 0);
        check_val("rst_data",  32'(bus_if.slow_data), 0);
        reset_n = 1'b1;
        @(posedge clk_sys); #1;

        // single TXT1 write in bank $00
        cpu_write(8'h00, 16'h0400, 8'h41);
        check_val("t1_level", 32'(level), 1);
        wait_req(SLOW_DIV, ok);
        check_val("t1_req_latency", 32'(ok), 1);
        check_val("t1_bank", 32'(bus_if.slow_bank), 0);
        check_val("t1_addr", 32'(bus_if.slow_addr), 32'h0400);
        check_val("t1_data", 32'(bus_if.slow_data), 32'h41);
        ack_once();
        check_val("t1_req_drop", 32'(bus_if.slow_req), 0);
        check_val("t1_level_after", 32'(level), 0);

        // bank $01 with AUX inhibit and SHR off: no region enabled
        shadow = 8'h18;
        cpu_write(8'h01, 16'h2000, 8'hAA);
        check_val("t2_aux_inhibit", 32'(level), 0);
        shadow = 8'h00;
        bus_if.io_n = 1'b0;
        cpu_write(8'h00, 16'h0400, 8'h55);
        check_val("t2_io_space", 32'(level), 0);
        bus_if.io_n = 1'b1;
        cpu_write(8'h00, 16'h0C00, 8'h55);
        check_val("t2_no_region", 32'(level), 0);
        cpu_write(8'h01, 16'h2000, 8'hAA);
        check_val("t2_level", 32'(level), 1);
        wait_req(SLOW_DIV, ok);
        check_val("t2_req", 32'(ok), 1);
        check_val("t2_bank", 32'(bus_if.slow_bank), 1);
        check_val("t2_addr", 32'(bus_if.slow_addr), 32'h2000);
        check_val("t2_data", 32'(bus_if.slow_data), 32'hAA);
        ack_once();
        check_val("t2_level_after", 32'(level), 0);

        // fill to DEPTH, ninth write must stall until a pop
        for (int i = 0; i < 8; i++) cpu_write(8'h00, 16'h0400 + 16'(i), 8'h10 + 8'(i));
        check_val("t3_full_level", 32'(level), 8);
        bus_if.cpu_strobe = 1'b1;
        bus_if.cpu_we     = 1'b1;
        bus_if.cpu_bank   = 8'h00;
        bus_if.cpu_addr   = 16'h0408;
        bus_if.cpu_dout   = 8'h18;
        #1;
        check_val("t3_stall_full", 32'(bus_if.stall), 1);
        @(posedge clk_sys); #1;
        check_val("t3_no_push", 32'(level), 8);
        wait_req(3 * SLOW_DIV, ok);
        check_val("t3_req", 32'(ok), 1);
        check_val("t3_head_addr", 32'(bus_if.slow_addr), 32'h0400);
        check_val("t3_head_data", 32'(bus_if.slow_data), 32'h10);
        check_val("t3_still_stall", 32'(bus_if.stall), 1);
        bus_if.slow_ack = 1'b1;
        #1;
        check_val("t3_stall_pop", 32'(bus_if.stall), 0);
        @(posedge clk_sys); #1;
        bus_if.cpu_strobe = 1'b0;
        bus_if.cpu_we     = 1'b0;
        bus_if.slow_ack   = 1'b0;
        check_val("t3_push_pop_level", 32'(level), 8);
        check_val("t3_req_drop", 32'(bus_if.slow_req), 0);
        wait_req(2 * SLOW_DIV, ok);
        check_val("t3_next_addr", 32'(bus_if.slow_addr), 32'h0401);
        check_val("t3_next_data", 32'(bus_if.slow_data), 32'h11);
        drain_all();

        // ordering hazard: read of $E1 while three writes are pending
        for (int i = 0; i < 3; i++) cpu_write(8'h00, 16'h0500 + 16'(i), 8'h20 + 8'(i));
        check_val("t4_level", 32'(level), 3);
        bus_if.cpu_strobe = 1'b1;
        bus_if.cpu_we     = 1'b0;
        bus_if.cpu_bank   = 8'hE1;
        bus_if.cpu_addr   = 16'h0400;
        #1;
        check_val("t4_stall", 32'(bus_if.stall), 1);
        early = 1'b0;
        n = 0;
        while (level != 0 && n < 200) begin
            @(posedge clk_sys); #1;
            if (level != 0 && !bus_if.stall) early = 1'b1;
            bus_if.slow_ack = bus_if.slow_req;
            n++;
        end
        bus_if.slow_ack = 1'b0;
        #1;
        check_val("t4_early_release", 32'(early), 0);
        check_val("t4_drained", 32'(level), 0);
        check_val("t4_stall_release", 32'(bus_if.stall), 0);
        bus_if.cpu_strobe = 1'b0;

        // Super Hi-Res region in bank $01
        shadow = 8'hF7;
        cpu_write(8'h01, 16'h9D00, 8'h0F);
`ifdef SHADOW_SHR_EN
        check_val("t5_shr_push", 32'(level), 1);
        wait_req(SLOW_DIV, ok);
        check_val("t5_shr_addr", 32'(bus_if.slow_addr), 32'h9D00);
        drain_all();
`else
        check_val("t5_shr_no_push", 32'(level), 0);
`endif
        shadow = 8'h00;

        // asynchronous reset mid-request
        for (int i = 0; i < 4; i++) cpu_write(8'h00, 16'h0600 + 16'(i), 8'h30 + 8'(i));
        wait_req(2 * SLOW_DIV, ok);
        check_val("t6_req_before", 32'(bus_if.slow_req), 1);
        check_val("t6_level_before", 32'(level), 4);
        #1;
        reset_n = 1'b0;
        #1;
        check_val("t6_req_rst", 32'(bus_if.slow_req), 0);
        check_val("t6_level_rst", 32'(level), 0);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3 * int'(SLOW_DIV); i++) begin
            bus_if.slow_ack = (i == 5);
            @(posedge clk_sys); #1;
            if (bus_if.slow_req) seen = 1'b1;
        end
        bus_if.slow_ack = 1'b0;
        check_val("t6_no_req", 32'(seen), 0);
        check_val("t6_level_idle", 32'(level), 0);
        cpu_write(8'h00, 16'h0800, 8'h5A);
        wait_req(SLOW_DIV, ok);
        check_val("t6_new_req", 32'(ok), 1);
        check_val("t6_new_addr", 32'(bus_if.slow_addr), 32'h0800);
        check_val("t6_new_data", 32'(bus_if.slow_data), 32'h5A);
        ack_once();
        check_val("t6_level_end", 32'(level), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
